// File: rtl/morse_encoder_pkg.sv
// Shared types and constants for the Morse encoder.
package morse_encoder_pkg;

  localparam int unsigned DOT_UNITS      = 1;
  localparam int unsigned DASH_UNITS     = 3;
  localparam int unsigned SYM_GAP_UNITS  = 1;
  localparam int unsigned CHAR_GAP_EXTRA = 2;
  localparam int unsigned WORD_GAP_EXTRA = 4;

  localparam int unsigned SYM_W  = 5;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned UNIT_W = 3;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MARK,
    ST_SPACE,
    ST_GAP
  } state_e;

  // Lookup result; pattern is left-aligned, MSB is the first symbol, 1 = dash.
  typedef struct packed {
    logic             valid;
    logic             is_space;
    logic [LEN_W-1:0] len;
    logic [SYM_W-1:0] pattern;
  } lut_t;

  function automatic lut_t mk_code(logic [LEN_W-1:0] len, logic [SYM_W-1:0] pattern);
    lut_t c;
    c.valid    = 1'b1;
    c.is_space = 1'b0;
    c.len      = len;
    c.pattern  = pattern;
    return c;
  endfunction

  function automatic logic [7:0] fold_upper(logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7a) return c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/morse_encoder_lut.sv
// Combinational ASCII (already upper-case) to Morse pattern lookup.
module morse_encoder_lut
  import morse_encoder_pkg::*;
(
  input  logic [7:0]       char_i,
  output logic             valid_o,
  output logic             is_space_o,
  output logic [LEN_W-1:0] len_o,
  output logic [SYM_W-1:0] pattern_o
);

  lut_t code;

  // Table of supported characters; anything else is reported invalid.
  always_comb begin
    code = '0;
    case (char_i)
      "A": code = mk_code(3'd2, 5'b01000);
      "B": code = mk_code(3'd4, 5'b10000);
      "C": code = mk_code(3'd4, 5'b10100);
      "D": code = mk_code(3'd3, 5'b10000);
      "E": code = mk_code(3'd1, 5'b00000);
      "F": code = mk_code(3'd4, 5'b00100);
      "G": code = mk_code(3'd3, 5'b11000);
      "H": code = mk_code(3'd4, 5'b00000);
      "I": code = mk_code(3'd2, 5'b00000);
      "J": code = mk_code(3'd4, 5'b01110);
      "K": code = mk_code(3'd3, 5'b10100);
      "L": code = mk_code(3'd4, 5'b01000);
      "M": code = mk_code(3'd2, 5'b11000);
      "N": code = mk_code(3'd2, 5'b10000);
      "O": code = mk_code(3'd3, 5'b11100);
      "P": code = mk_code(3'd4, 5'b01100);
      "Q": code = mk_code(3'd4, 5'b11010);
      "R": code = mk_code(3'd3, 5'b01000);
      "S": code = mk_code(3'd3, 5'b00000);
      "T": code = mk_code(3'd1, 5'b10000);
      "U": code = mk_code(3'd3, 5'b00100);
      "V": code = mk_code(3'd4, 5'b00010);
      "W": code = mk_code(3'd3, 5'b01100);
      "X": code = mk_code(3'd4, 5'b10010);
      "Y": code = mk_code(3'd4, 5'b10110);
      "Z": code = mk_code(3'd4, 5'b11000);
      "0": code = mk_code(3'd5, 5'b11111);
      "1": code = mk_code(3'd5, 5'b01111);
      "2": code = mk_code(3'd5, 5'b00111);
      "3": code = mk_code(3'd5, 5'b00011);
      "4": code = mk_code(3'd5, 5'b00001);
      "5": code = mk_code(3'd5, 5'b00000);
      "6": code = mk_code(3'd5, 5'b10000);
      "7": code = mk_code(3'd5, 5'b11000);
      "8": code = mk_code(3'd5, 5'b11100);
      "9": code = mk_code(3'd5, 5'b11110);
      ASCII_SPACE: code.is_space = 1'b1;
      default: code = '0;
    endcase
  end

  assign valid_o    = code.valid;
  assign is_space_o = code.is_space;
  assign len_o      = code.len;
  assign pattern_o  = code.pattern;

endmodule

// File: rtl/morse_encoder.sv
// FIFO reader that keys out one character at a time in Morse with unit timing.
module morse_encoder
  import morse_encoder_pkg::*;
#(
  parameter int unsigned WORD_BITS     = 8,
  parameter int unsigned CLKS_PER_UNIT = 6_000_000
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 empty_i,
  input  logic [WORD_BITS-1:0] rdata_i,
  output logic                 read_o,
  output logic                 key_o,
  output logic                 busy_o
);

  localparam int unsigned     CYC_W    = $clog2(CLKS_PER_UNIT) + 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_UNIT - 1);

  state_e              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [UNIT_W-1:0]   unit_q, unit_d;
  logic [SYM_W-1:0]    sym_q, sym_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [WORD_BITS-1:0] char_q, char_d;
  logic                key_q, busy_q;

  logic                read_c;
  logic [UNIT_W-1:0]   span_units_c;
  logic                span_done_c;

  logic                lut_valid;
  logic                lut_is_space;
  logic [LEN_W-1:0]    lut_len;
  logic [SYM_W-1:0]    lut_pattern;

  // Lookup always sees the held character, case-folded.
  morse_encoder_lut u_lut (
    .char_i     (fold_upper(8'(char_q))),
    .valid_o    (lut_valid),
    .is_space_o (lut_is_space),
    .len_o      (lut_len),
    .pattern_o  (lut_pattern)
  );

  // State, timers, symbol shifter and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      sym_q   <= '0;
      cnt_q   <= '0;
      char_q  <= '0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      key_q   <= (state_d == ST_MARK);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Next-state, pop strobe and unit timer control.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    unit_d       = unit_q;
    sym_d        = sym_q;
    cnt_d        = cnt_q;
    char_d       = char_q;
    read_c       = 1'b0;
    span_units_c = UNIT_W'(DOT_UNITS);

    // Length of the current timed span in units.
    case (state_q)
      ST_MARK:  span_units_c = sym_q[SYM_W-1] ? UNIT_W'(DASH_UNITS) : UNIT_W'(DOT_UNITS);
      ST_SPACE: span_units_c = UNIT_W'(SYM_GAP_UNITS);
      ST_GAP:   span_units_c = lut_is_space ? UNIT_W'(WORD_GAP_EXTRA) : UNIT_W'(CHAR_GAP_EXTRA);
      default:  span_units_c = UNIT_W'(DOT_UNITS);
    endcase
    span_done_c = (cyc_q == CYC_LAST) && (unit_q == span_units_c - UNIT_W'(1));

    if (state_q inside {ST_MARK, ST_SPACE, ST_GAP}) begin
      if (cyc_q == CYC_LAST) begin
        cyc_d  = '0;
        unit_d = unit_q + UNIT_W'(1);
      end else begin
        cyc_d = cyc_q + CYC_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!empty_i && reset_n_i) begin
          read_c  = 1'b1;
          char_d  = rdata_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (lut_valid) begin
          sym_d   = lut_pattern;
          cnt_d   = lut_len;
          state_d = ST_MARK;
        end else if (lut_is_space) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MARK: begin
        if (span_done_c) state_d = ST_SPACE;
      end
      ST_SPACE: begin
        if (span_done_c) begin
          if (cnt_q > LEN_W'(1)) begin
            sym_d   = {sym_q[SYM_W-2:0], 1'b0};
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = ST_MARK;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (span_done_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Every span starts its timer from zero.
    if (state_d != state_q) begin
      cyc_d  = '0;
      unit_d = '0;
    end
  end

  assign read_o = read_c;
  assign key_o  = key_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench: each pushed char queues its expected per-cycle key waveform.
module tb_morse_encoder;

  localparam int CPU = 4;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       empty_i;
  logic [7:0] rdata_i;
  logic       read_o, key_o, busy_o;

  always #5 clk_i = ~clk_i;

  morse_encoder #(.WORD_BITS(8), .CLKS_PER_UNIT(CPU)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .empty_i   (empty_i),
    .rdata_i   (rdata_i),
    .read_o    (read_o),
    .key_o     (key_o),
    .busy_o    (busy_o)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int n_push = 0;
  int n_read = 0;
  bit mon_en = 1'b0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_c[$];
  string      exp_w[$];

  string morse_tbl [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };

  // Expected key level for each busy cycle, starting with the load cycle.
  function automatic string wave_of(logic [7:0] c);
    logic [7:0] u;
    string      w;
    string      m;
    int         idx;
    int         len;
    u   = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    w   = "0";
    idx = -1;
    if (u >= 8'h41 && u <= 8'h5a) idx = int'(u) - 65;
    else if (u >= 8'h30 && u <= 8'h39) idx = 26 + int'(u) - 48;
    if (u == 8'h20) begin
      for (int k = 0; k < 4 * CPU; k++) w = {w, "0"};
    end else if (idx >= 0) begin
      m = morse_tbl[idx];
      for (int s = 0; s < m.len(); s++) begin
        len = (m[s] == "-") ? 3 * CPU : CPU;
        for (int k = 0; k < len; k++) w = {w, "1"};
        for (int k = 0; k < CPU; k++) w = {w, "0"};
      end
      for (int k = 0; k < 2 * CPU; k++) w = {w, "0"};
    end
    return w;
  endfunction

  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 8'(65 + $urandom_range(0, 25));
      4:          return 8'(97 + $urandom_range(0, 25));
      5, 6:       return 8'(48 + $urandom_range(0, 9));
      7:          return 8'h20;
      8:          return 8'($urandom);
      default:    return 8'(33 + $urandom_range(0, 14));
    endcase
  endfunction

  task automatic check(string name, int act, int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // FIFO head drive; data is garbage whenever the FIFO is empty.
  task automatic refresh();
    empty_i = (fifo_q.size() == 0);
    rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
  endtask

  task automatic step();
    bit pop;
    @(negedge clk_i);
    pop = read_o;
    @(posedge clk_i);
    #1;
    if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh();
  endtask

  task automatic push(logic [7:0] c);
    fifo_q.push_back(c);
    exp_c.push_back(c);
    exp_w.push_back(wave_of(c));
    n_push++;
    refresh();
  endtask

  task automatic drain(int budget);
    int done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (fifo_q.size() == 0 && exp_w.size() == 0 && busy_o === 1'b0 && read_o === 1'b0) begin
        done = 1;
        break;
      end
    end
    check("drain_timeout", done, 1);
    repeat (2) step();
  endtask

  // Monitor: on each pop, compare the following busy period against the queued waveform.
  initial begin
    string      w;
    logic [7:0] c;
    bit         bad;
    forever begin
      @(negedge clk_i);
      while (mon_en && read_o === 1'b1) begin
        n_read++;
        n_vec++;
        if (busy_o !== 1'b0 || key_o !== 1'b0) begin
          n_err++;
          $display("FAIL pop_cycle: busy=%b key=%b expected busy=0 key=0", busy_o, key_o);
        end
        if (exp_w.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pop: read_o=1 with no char pending, expected no pop");
          @(negedge clk_i);
          continue;
        end
        w   = exp_w.pop_front();
        c   = exp_c.pop_front();
        bad = 1'b0;
        for (int i = 0; i < w.len(); i++) begin
          @(negedge clk_i);
          if (!mon_en) break;
          if (!bad) begin
            n_vec++;
            if (key_o !== (w[i] == "1") || busy_o !== 1'b1 || read_o !== 1'b0) begin
              n_err++;
              bad = 1'b1;
              $display("FAIL trace char=%02h cycle %0d: key=%b busy=%b read=%b, expected key=%b busy=1 read=0",
                       c, i, key_o, busy_o, read_o, (w[i] == "1"));
            end
          end
        end
        @(negedge clk_i);
      end
      if (mon_en) begin
        n_vec++;
        if (busy_o !== 1'b0 || key_o !== 1'b0) begin
          n_err++;
          $display("FAIL idle: busy=%b key=%b expected busy=0 key=0", busy_o, key_o);
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    reset_n_i = 1'b0;
    empty_i   = 1'b1;
    rdata_i   = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_read", int'(read_o), 0);
    check("reset_key", int'(key_o), 0);
    check("reset_busy", int'(busy_o), 0);
    reset_n_i = 1'b1;
    mon_en    = 1'b1;
    refresh();
    repeat (3) step();

    // Directed characters.
    push("E");                                 drain(200);
    push("A");                                 drain(200);
    push("S"); push("O"); push("S");           drain(500);
    push("E"); push(8'h20); push("E");         drain(500);
    push(8'h23); push("e");                    drain(200);
    push("0"); push("z");                      drain(500);

    // Random traffic, sometimes queued behind a busy encoder.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(1, 3)) push(rand_char());
      repeat ($urandom_range(0, 80)) step();
    end
    drain(20000);

    // Reset in the middle of a dash.
    push("T");
    found = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (key_o === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("dash_start_seen", found, 1);
    repeat (5) step();
    #2;
    mon_en    = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check("async_rst_key", int'(key_o), 0);
    check("async_rst_busy", int'(busy_o), 0);
    check("async_rst_read", int'(read_o), 0);
    repeat (3) step();
    exp_c.delete();
    exp_w.delete();
    fifo_q.delete();
    refresh();
    #2;
    reset_n_i = 1'b1;
    mon_en    = 1'b1;
    repeat (20) step();
    check("post_rst_idle_busy", int'(busy_o), 0);
    check("post_rst_idle_key", int'(key_o), 0);

    // No pop while held in reset, normal operation after release.
    #2;
    mon_en    = 1'b0;
    reset_n_i = 1'b0;
    push("E");
    #1;
    check("rst_hold_read", int'(read_o), 0);
    step();
    #2;
    mon_en    = 1'b1;
    reset_n_i = 1'b1;
    drain(200);

    check("pop_count", n_read, n_push);
    check("fifo_left", fifo_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
